motor_pwm_gen: RTL and testbench

Dual-channel H-bridge PWM generator that consumes the right/left motor control registers written over APB3 (8-bit duty, enable, direction per channel). It produces the four H-bridge gate signals.
- Settings are captured only at PWM period boundaries, so the waveform is glitch-free.
- A direction reversal inserts a dead interval of whole periods, so a motor is never reversed under drive.
- Sits directly downstream of the APB control-register block, in the PCLK domain.

---
 rtl/motor_pwm_gen.sv | 155 +++++++++++++++
 tb/tb_motor_pwm_gen.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_gen.sv
// ---------------------------------------------------------------------------
// motor_pwm_gen
// Dual-channel H-bridge PWM generator (right = channel 0, left = channel 1).
// A shared prescaler and 8-bit counter define a 256-step PWM period. Duty,
// enable and direction are sampled only on the period boundary, so every
// period is glitch-free. A direction reversal parks the channel for
// DEADTIME_PERIODS whole periods with both bridge legs low.
//
// Ports:
//   PCLK, PRESERN          clock, asynchronous active-low reset
//   PWM_DUTY_R/L [7:0]     high count per period (counter steps)
//   PWM_EN_R/L             channel enable
//   PWM_DIR_R/L            0 = forward (A leg), 1 = reverse (B leg)
//   MOTOR_R_A/B, L_A/B     registered H-bridge gate drives
//   PERIOD_TICK            one-cycle pulse in the first cycle of each period
// ---------------------------------------------------------------------------
module motor_pwm_gen #(
  parameter int PRESCALE         = 4,
  parameter int DEADTIME_PERIODS = 2
) (
  input  logic       PCLK,
  input  logic       PRESERN,
  input  logic [7:0] PWM_DUTY_R,
  input  logic [7:0] PWM_DUTY_L,
  input  logic       PWM_EN_R,
  input  logic       PWM_EN_L,
  input  logic       PWM_DIR_R,
  input  logic       PWM_DIR_L,
  output logic       MOTOR_R_A,
  output logic       MOTOR_R_B,
  output logic       MOTOR_L_A,
  output logic       MOTOR_L_B,
  output logic       PERIOD_TICK
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  // Loaded when entering DEAD; the DEAD state is unreachable when the
  // dead time is zero, so the clamp only keeps the constant legal.
  localparam logic [DW-1:0] DEAD_INIT =
    (DEADTIME_PERIODS > 0) ? DW'(DEADTIME_PERIODS - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // ---------------- shared timebase ----------------
  logic [PW-1:0] r_presc_cnt;
  logic [7:0]    r_pwm_cnt;
  logic          r_period_tick;
  logic          w_tick;
  logic          w_boundary;

  assign w_tick     = (r_presc_cnt == PRESC_MAX);
  assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_presc_cnt   <= '0;
      r_pwm_cnt     <= '0;
      r_period_tick <= 1'b0;
    end else begin
      r_presc_cnt   <= w_tick ? '0 : r_presc_cnt + 1'b1;
      // 8-bit wrap 255 -> 0 coincides with the boundary
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_period_tick <= w_boundary;
    end
  end

  // ---------------- per-channel control ----------------
  logic [1:0][7:0] w_duty_in;
  logic [1:0]      w_en_in;
  logic [1:0]      w_dir_in;

  assign w_duty_in = {PWM_DUTY_L, PWM_DUTY_R};
  assign w_en_in   = {PWM_EN_L, PWM_EN_R};
  assign w_dir_in  = {PWM_DIR_L, PWM_DIR_R};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_t        r_state;
    logic          r_dir_act;
    logic [DW-1:0] r_dead_cnt;
    logic [7:0]    r_duty_s;
    logic          r_en_s;
    logic          r_out_a;
    logic          r_out_b;
    logic          w_on;

    assign w_on = (r_state == ST_DRIVE) && r_en_s && (r_pwm_cnt < r_duty_s);

    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        r_state    <= ST_IDLE;
        r_dir_act  <= 1'b0;
        r_dead_cnt <= '0;
        r_duty_s   <= '0;
        r_en_s     <= 1'b0;
        r_out_a    <= 1'b0;
        r_out_b    <= 1'b0;
      end else begin
        // A single dir_act bit steers the pulse, so A and B can never overlap.
        r_out_a <= w_on && !r_dir_act;
        r_out_b <= w_on && r_dir_act;
        if (w_boundary) begin
          r_duty_s <= w_duty_in[g];
          r_en_s   <= w_en_in[g];
          case (r_state)
            ST_IDLE: begin
              // Coasting already, so a new direction applies immediately.
              if (w_en_in[g]) begin
                r_state   <= ST_DRIVE;
                r_dir_act <= w_dir_in[g];
              end
            end
            ST_DRIVE: begin
              if (!w_en_in[g]) begin
                r_state <= ST_IDLE;
              end else if (w_dir_in[g] != r_dir_act) begin
                if (DEADTIME_PERIODS == 0) begin
                  r_dir_act <= w_dir_in[g];
                end else begin
                  r_state    <= ST_DEAD;
                  r_dead_cnt <= DEAD_INIT;
                end
              end
            end
            ST_DEAD: begin
              if (!w_en_in[g]) begin
                r_state    <= ST_IDLE;
                r_dead_cnt <= '0;
              end else if (r_dead_cnt == '0) begin
                // Resume in whatever direction is requested now.
                r_state   <= ST_DRIVE;
                r_dir_act <= w_dir_in[g];
              end else begin
                r_dead_cnt <= r_dead_cnt - 1'b1;
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign MOTOR_R_A   = g_ch[0].r_out_a;
  assign MOTOR_R_B   = g_ch[0].r_out_b;
  assign MOTOR_L_A   = g_ch[1].r_out_a;
  assign MOTOR_L_B   = g_ch[1].r_out_b;
  assign PERIOD_TICK = r_period_tick;

endmodule

// File: tb/tb_motor_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_motor_pwm_gen
// Two instances share all inputs: dut0 (PRESCALE=1) and dut1 (PRESCALE=4),
// both with a two-period dead time. A period-level reference model predicts
// every output of both instances on every cycle; scenario tasks add
// per-period pulse-width and timing checks.
// ---------------------------------------------------------------------------
module tb_motor_pwm_gen;

  localparam int DEADP = 2;

  // ---------------- clock / reset ----------------
  logic       PCLK;
  logic       PRESERN;
  logic [7:0] PWM_DUTY_R, PWM_DUTY_L;
  logic       PWM_EN_R, PWM_EN_L, PWM_DIR_R, PWM_DIR_L;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic r_a0, r_b0, l_a0, l_b0, pt0;
  logic r_a1, r_b1, l_a1, l_b1, pt1;
  logic [4:0] obs0, obs1;
  assign obs0 = {r_a0, r_b0, l_a0, l_b0, pt0};
  assign obs1 = {r_a1, r_b1, l_a1, l_b1, pt1};

  motor_pwm_gen #(.PRESCALE(1), .DEADTIME_PERIODS(DEADP)) dut0 (
    .PCLK(PCLK), .PRESERN(PRESERN),
    .PWM_DUTY_R(PWM_DUTY_R), .PWM_DUTY_L(PWM_DUTY_L),
    .PWM_EN_R(PWM_EN_R), .PWM_EN_L(PWM_EN_L),
    .PWM_DIR_R(PWM_DIR_R), .PWM_DIR_L(PWM_DIR_L),
    .MOTOR_R_A(r_a0), .MOTOR_R_B(r_b0), .MOTOR_L_A(l_a0), .MOTOR_L_B(l_b0),
    .PERIOD_TICK(pt0)
  );

  motor_pwm_gen #(.PRESCALE(4), .DEADTIME_PERIODS(DEADP)) dut1 (
    .PCLK(PCLK), .PRESERN(PRESERN),
    .PWM_DUTY_R(PWM_DUTY_R), .PWM_DUTY_L(PWM_DUTY_L),
    .PWM_EN_R(PWM_EN_R), .PWM_EN_L(PWM_EN_L),
    .PWM_DIR_R(PWM_DIR_R), .PWM_DIR_L(PWM_DIR_L),
    .MOTOR_R_A(r_a1), .MOTOR_R_B(r_b1), .MOTOR_L_A(l_a1), .MOTOR_L_B(l_b1),
    .PERIOD_TICK(pt1)
  );

  int total = 0;
  int bad   = 0;
  int nprint = 0;

  // ---------------- reference model ----------------
  // Works on whole periods: at each boundary it decides how the coming
  // period is driven (off / A / B and its duty). Within a period the pulse
  // occupies positions 1 .. duty*PRESCALE after the boundary.
  int pre_of [2] = '{1, 4};
  int ecnt [2];
  bit engaged [2][2];
  bit in_dead [2][2];
  bit cur_dir [2][2];
  int dead_left [2][2];
  int duty_p [2][2];
  logic [4:0] exp_v [2];
  int m_len, m_pos, m_duty;
  bit m_en, m_dir, m_hi;
  bit m_hi_a [2];
  bit m_hi_b [2];

  always @(posedge PCLK or negedge PRESERN) begin
    for (int i = 0; i < 2; i++) begin
      if (!PRESERN) begin
        ecnt[i]  = 0;
        exp_v[i] = '0;
        for (int c = 0; c < 2; c++) begin
          engaged[i][c] = 0; in_dead[i][c] = 0; cur_dir[i][c] = 0;
          dead_left[i][c] = 0; duty_p[i][c] = 0;
        end
      end else begin
        ecnt[i] = ecnt[i] + 1;
        m_len = 256 * pre_of[i];
        m_pos = ecnt[i] % m_len;
        for (int c = 0; c < 2; c++) begin
          if (m_pos == 0) begin
            m_en   = (c == 0) ? PWM_EN_R : PWM_EN_L;
            m_dir  = (c == 0) ? PWM_DIR_R : PWM_DIR_L;
            m_duty = (c == 0) ? int'(PWM_DUTY_R) : int'(PWM_DUTY_L);
            duty_p[i][c] = m_duty;
            if (!m_en) begin
              engaged[i][c] = 0; in_dead[i][c] = 0;
            end else if (!engaged[i][c]) begin
              engaged[i][c] = 1; in_dead[i][c] = 0; cur_dir[i][c] = m_dir;
            end else if (in_dead[i][c]) begin
              if (dead_left[i][c] == 0) begin
                in_dead[i][c] = 0; cur_dir[i][c] = m_dir;
              end else begin
                dead_left[i][c] = dead_left[i][c] - 1;
              end
            end else if (m_dir != cur_dir[i][c]) begin
              if (DEADP == 0) cur_dir[i][c] = m_dir;
              else begin
                in_dead[i][c] = 1; dead_left[i][c] = DEADP - 1;
              end
            end
          end
          m_hi = engaged[i][c] && !in_dead[i][c] && m_pos >= 1 &&
                 m_pos <= duty_p[i][c] * pre_of[i];
          m_hi_a[c] = m_hi && !cur_dir[i][c];
          m_hi_b[c] = m_hi && cur_dir[i][c];
        end
        exp_v[i] = {m_hi_a[0], m_hi_b[0], m_hi_a[1], m_hi_b[1],
                    (m_pos == 0) && (ecnt[i] >= m_len)};
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_tick(input int which);
    int n;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while ((((which == 0) ? pt0 : pt1) !== 1'b1) && n < 1100);
    total++;
    if (((which == 0) ? pt0 : pt1) !== 1'b1) begin
      bad++;
      $display("FAIL wait_tick dut%0d: no PERIOD_TICK within %0d cycles (got 0, need 1)", which, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    PRESERN = 1'b1;
    PWM_DUTY_R = 0; PWM_DUTY_L = 0;
    PWM_EN_R = 0; PWM_EN_L = 0; PWM_DIR_R = 0; PWM_DIR_L = 0;
    #1 PRESERN = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== 10'b0) begin
        bad++;
        $display("FAIL reset_hold got=%b need=0000000000", {obs0, obs1});
      end
    end
    PRESERN = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
      end
    end
  endtask

  task automatic test_basic;
    int ha, hx;
    wait_tick(0);
    ha = 0; hx = 0;
    for (int k = 1; k < 4 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL basic_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      if (k == 100) begin PWM_DUTY_R = 64; PWM_EN_R = 1; PWM_DIR_R = 0; end
      ha += int'(r_a0);
      hx += int'(r_b0) + int'(l_a0) + int'(l_b0);
      if (k % 256 == 255) begin
        total++;
        if (ha != ((k / 256 == 0) ? 0 : 64) || hx != 0) begin
          bad++;
          $display("FAIL basic_width period=%0d got R_A=%0d others=%0d need R_A=%0d others=0",
                   k / 256, ha, hx, (k / 256 == 0) ? 0 : 64);
        end
        ha = 0; hx = 0;
      end
    end
  endtask

  task automatic test_duty_edges;
    int hl;
    wait_tick(0);
    hl = 0;
    for (int k = 1; k < 4 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL duty_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      if (k == 10) begin PWM_EN_L = 1; PWM_DUTY_L = 0; PWM_DIR_L = 0; end
      if (k == 256 + 10) PWM_DUTY_L = 255;
      hl += int'(l_a0);
      if (k % 256 == 255) begin
        total++;
        if (hl != ((k / 256 >= 2) ? 255 : 0)) begin
          bad++;
          $display("FAIL duty_width period=%0d got L_A=%0d need %0d", k / 256, hl, (k / 256 >= 2) ? 255 : 0);
        end
        hl = 0;
      end
    end
  endtask

  task automatic test_reverse;
    int exp_a [6] = '{64, 128, 0, 0, 0, 0};
    int exp_b [6] = '{0, 0, 0, 0, 128, 128};
    int ha, hb;
    wait_tick(0);
    ha = 0; hb = 0;
    for (int k = 1; k < 6 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL reverse_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      total++;
      if ((r_a0 & r_b0) | (l_a0 & l_b0) | (r_a1 & r_b1) | (l_a1 & l_b1)) begin
        bad++;
        $display("FAIL reverse_overlap cyc=%0d got A&B=1 need 0", k);
      end
      if (k == 10) PWM_DUTY_R = 128;
      if (k == 256 + 100) PWM_DIR_R = 1;
      ha += int'(r_a0);
      hb += int'(r_b0);
      if (k % 256 == 255) begin
        total++;
        if (ha != exp_a[k / 256] || hb != exp_b[k / 256]) begin
          bad++;
          $display("FAIL reverse_width period=%0d got A=%0d B=%0d need A=%0d B=%0d",
                   k / 256, ha, hb, exp_a[k / 256], exp_b[k / 256]);
        end
        ha = 0; hb = 0;
      end
    end
  endtask

  task automatic test_enable_drop;
    int exp_a [5] = '{0, 0, 0, 200, 200};
    int exp_b [5] = '{128, 200, 0, 0, 0};
    int ha, hb;
    wait_tick(0);
    ha = 0; hb = 0;
    for (int k = 1; k < 5 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL endrop_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      if (k == 10) PWM_DUTY_R = 200;
      if (k == 256 + 50) PWM_EN_R = 0;
      if (k == 512 + 50) begin PWM_EN_R = 1; PWM_DIR_R = 0; end
      ha += int'(r_a0);
      hb += int'(r_b0);
      if (k % 256 == 255) begin
        total++;
        if (ha != exp_a[k / 256] || hb != exp_b[k / 256]) begin
          bad++;
          $display("FAIL endrop_width period=%0d got A=%0d B=%0d need A=%0d B=%0d",
                   k / 256, ha, hb, exp_a[k / 256], exp_b[k / 256]);
        end
        ha = 0; hb = 0;
      end
    end
  endtask

  task automatic test_prescale;
    int ha, last;
    PWM_EN_R = 0;
    wait_tick(1);
    PWM_EN_R = 1; PWM_DUTY_R = 128; PWM_DIR_R = 0;
    wait_tick(1);
    ha = 0; last = 0;
    for (int k = 1; k < 3 * 1024; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL presc_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      if (pt1 === 1'b1) begin
        total++;
        if (k - last != 1024) begin
          bad++;
          $display("FAIL presc_tick_spacing got=%0d need=1024", k - last);
        end
        last = k;
      end
      ha += int'(r_a1);
      if (k % 1024 == 1023) begin
        total++;
        if (ha != 512) begin
          bad++;
          $display("FAIL presc_width period=%0d got R_A=%0d need 512", k / 1024, ha);
        end
        ha = 0;
      end
    end
  endtask

  task automatic test_async_reset;
    int first_tick, hpre, hpost;
    // -- reset in the middle of a high pulse --
    PWM_DUTY_R = 200;
    wait_tick(0);
    for (int k = 1; k <= 50; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL rst_pre_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
    end
    total++;
    if (r_a0 !== 1'b1) begin
      bad++;
      $display("FAIL rst_pulse_high got R_A=%b need 1", r_a0);
    end
    #2 PRESERN = 1'b0;
    #1;
    total++;
    if ({obs0, obs1} !== 10'b0) begin
      bad++;
      $display("FAIL rst_async_pulse got=%b need=0000000000", {obs0, obs1});
    end
    repeat (3) @(negedge PCLK);
    PWM_DUTY_R = 32; PWM_DIR_R = 1; PWM_EN_R = 1;
    PWM_DUTY_L = 255; PWM_DIR_L = 0; PWM_EN_L = 1;
    PRESERN = 1'b1;
    first_tick = -1; hpre = 0; hpost = 0;
    for (int k = 1; k < 2 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL rst_post_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      if (pt0 === 1'b1 && first_tick < 0) first_tick = k;
      if (k <= 256) hpre += int'(r_a0) + int'(r_b0) + int'(l_a0) + int'(l_b0);
      else hpost += int'(r_b0);
    end
    total++;
    if (first_tick != 256 || hpre != 0 || hpost != 32) begin
      bad++;
      $display("FAIL rst_first_period got tick=%0d pre=%0d R_B=%0d need tick=256 pre=0 R_B=32",
               first_tick, hpre, hpost);
    end
    // -- reset in the middle of a dead interval --
    wait_tick(0);
    for (int k = 1; k <= 256 + 99; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL dead_pre_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      if (k == 100) PWM_DIR_R = 0;
    end
    total++;
    if (r_a0 !== 1'b0 || r_b0 !== 1'b0 || l_a0 !== 1'b1) begin
      bad++;
      $display("FAIL dead_state got R_A=%b R_B=%b L_A=%b need 0 0 1", r_a0, r_b0, l_a0);
    end
    #2 PRESERN = 1'b0;
    #1;
    total++;
    if ({obs0, obs1} !== 10'b0) begin
      bad++;
      $display("FAIL rst_async_dead got=%b need=0000000000", {obs0, obs1});
    end
    repeat (2) @(negedge PCLK);
    PRESERN = 1'b1;
    hpre = 0; hpost = 0;
    for (int k = 1; k < 2 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL dead_post_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      hpre += int'(r_b0);
      if (k > 256) hpost += int'(r_a0);
    end
    total++;
    if (hpre != 0 || hpost != 32) begin
      bad++;
      $display("FAIL dead_cleared got R_B=%0d R_A=%0d need R_B=0 R_A=32", hpre, hpost);
    end
  endtask

  task automatic test_random;
    for (int k = 1; k <= 20 * 256; k++) begin
      @(negedge PCLK);
      total++;
      if ({obs0, obs1} !== {exp_v[0], exp_v[1]}) begin
        bad++;
        if (nprint < 20) $display("FAIL random_model cyc=%0d got=%b need=%b", k, {obs0, obs1}, {exp_v[0], exp_v[1]});
        nprint++;
      end
      total++;
      if ((r_a0 & r_b0) | (l_a0 & l_b0) | (r_a1 & r_b1) | (l_a1 & l_b1)) begin
        bad++;
        $display("FAIL random_overlap cyc=%0d got A&B=1 need 0", k);
      end
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 7))
          0: PWM_DUTY_R = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
          1: PWM_DUTY_L = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
          2: PWM_EN_R = ~PWM_EN_R;
          3: PWM_EN_L = ~PWM_EN_L;
          4, 5: PWM_DIR_R = ~PWM_DIR_R;
          default: PWM_DIR_L = ~PWM_DIR_L;
        endcase
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_duty_edges();
    test_reverse();
    test_enable_drop();
    test_prescale();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
